// File: rtl/instr_dispatch_pkg.sv
// Shared constants for the dispatcher: opcodes, reservation-station tag map,
// FSM state encoding and instruction field positions.
package instr_dispatch_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;

    localparam int TAG_NONE     = 0;
    localparam int TAG_ADD_BASE = 1;
    localparam int TAG_MUL_BASE = 4;
    localparam int N_ADD_RS     = 3;
    localparam int N_MUL_RS     = 2;
    localparam int RS_IDX_W     = 2;

    localparam int OP_LSB = 12;
    localparam int RD_LSB = 8;
    localparam int RS_LSB = 4;
    localparam int RT_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_STALL,
        ST_ISSUE
    } state_e;

    function automatic logic op_is_add(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic op_is_mul(input logic [3:0] op);
        return (op == OP_MUL);
    endfunction

endpackage

// File: rtl/instr_dispatch_if.sv
// Dispatcher bus: instruction queue, station busy flags, register file and
// register-status read ports, CDB snoop and issue/status-update outputs.
interface instr_dispatch_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
);
    logic              Queue_Empty;
    logic [15:0]       Queue_Instr;
    logic              Pop;
    logic [2:0]        Add_Busy;
    logic [1:0]        Mul_Busy;
    logic [3:0]        Rf_Addr_J;
    logic [3:0]        Rf_Addr_K;
    logic [DATA_W-1:0] Rf_Data_J;
    logic [DATA_W-1:0] Rf_Data_K;
    logic [TAG_W-1:0]  Rst_Qi_J;
    logic [TAG_W-1:0]  Rst_Qi_K;
    logic              Cdb_Valid;
    logic [TAG_W-1:0]  Cdb_Tag;
    logic [DATA_W-1:0] Cdb_Data;
    logic              Issue_Valid;
    logic [TAG_W-1:0]  Issue_Tag;
    logic [3:0]        Issue_Op;
    logic [DATA_W-1:0] Issue_Vj;
    logic [DATA_W-1:0] Issue_Vk;
    logic [TAG_W-1:0]  Issue_Qj;
    logic [TAG_W-1:0]  Issue_Qk;
    logic              Rst_Write;
    logic [3:0]        Rst_Addr;
    logic [TAG_W-1:0]  Rst_Tag;
    logic              Illegal;

    modport master (
        input  Queue_Empty, Queue_Instr, Add_Busy, Mul_Busy,
               Rf_Data_J, Rf_Data_K, Rst_Qi_J, Rst_Qi_K,
               Cdb_Valid, Cdb_Tag, Cdb_Data,
        output Pop, Rf_Addr_J, Rf_Addr_K, Issue_Valid, Issue_Tag, Issue_Op,
               Issue_Vj, Issue_Vk, Issue_Qj, Issue_Qk,
               Rst_Write, Rst_Addr, Rst_Tag, Illegal
    );

    modport slave (
        output Queue_Empty, Queue_Instr, Add_Busy, Mul_Busy,
               Rf_Data_J, Rf_Data_K, Rst_Qi_J, Rst_Qi_K,
               Cdb_Valid, Cdb_Tag, Cdb_Data,
        input  Pop, Rf_Addr_J, Rf_Addr_K, Issue_Valid, Issue_Tag, Issue_Op,
               Issue_Vj, Issue_Vk, Issue_Qj, Issue_Qk,
               Rst_Write, Rst_Addr, Rst_Tag, Illegal
    );
endinterface

// File: rtl/instr_dispatch_rs_select.sv
// Priority picker: lowest-index clear bit of a busy vector plus a found flag.
// Latency: combinational. Backpressure: none (pure function of busy).
module rs_select #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     busy,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan high to low so the lowest free index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/instr_dispatch.sv
// Single-issue dispatcher: pops the queue head, picks a free station, issues.
// Latency: Pop at cycle N -> Issue_Valid at N+2; stalls in STALL while the class is full.
// Backpressure: no new Pop until back in IDLE. CDB bypass under DISPATCH_CDB_BYPASS_EN.
module instr_dispatch
    import instr_dispatch_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
) (
    input logic       clk,
    input logic       rst_n,
    instr_dispatch_if.master bus
);
    state_e            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
    logic [TAG_W-1:0]  qj_q, qj_d, qk_q, qk_d;
    logic              illegal_q, illegal_d;
    logic              pop;

    logic [3:0]          ir_op;
    logic [RS_IDX_W-1:0] add_idx, mul_idx;
    logic                add_found, mul_found;
    logic                sel_found;
    logic [TAG_W-1:0]    sel_tag;
    logic [DATA_W-1:0]   opnd_vj, opnd_vk;
    logic [TAG_W-1:0]    opnd_qj, opnd_qk;

    assign ir_op = ir_q[OP_LSB +: 4];

    rs_select #(.N(N_ADD_RS), .IDX_W(RS_IDX_W)) u_add_sel (
        .busy  (bus.Add_Busy),
        .idx   (add_idx),
        .found (add_found)
    );

    rs_select #(.N(N_MUL_RS), .IDX_W(RS_IDX_W)) u_mul_sel (
        .busy  (bus.Mul_Busy),
        .idx   (mul_idx),
        .found (mul_found)
    );

    always_comb begin
        sel_found = 1'b0;
        sel_tag   = TAG_W'(TAG_NONE);
        if (op_is_add(ir_op)) begin
            sel_found = add_found;
            sel_tag   = TAG_W'(TAG_ADD_BASE + int'(add_idx));
        end else if (op_is_mul(ir_op)) begin
            sel_found = mul_found;
            sel_tag   = TAG_W'(TAG_MUL_BASE + int'(mul_idx));
        end
    end

    // Operands as they would be captured this cycle; status tags are read
    // before this instruction's own status write, so Rd==Rs/Rt is safe.
    always_comb begin
        opnd_qj = bus.Rst_Qi_J;
        opnd_qk = bus.Rst_Qi_K;
        opnd_vj = (bus.Rst_Qi_J == TAG_W'(TAG_NONE)) ? bus.Rf_Data_J : '0;
        opnd_vk = (bus.Rst_Qi_K == TAG_W'(TAG_NONE)) ? bus.Rf_Data_K : '0;
`ifdef DISPATCH_CDB_BYPASS_EN
        if (bus.Cdb_Valid && (bus.Rst_Qi_J != TAG_W'(TAG_NONE)) && (bus.Cdb_Tag == bus.Rst_Qi_J)) begin
            opnd_vj = bus.Cdb_Data;
            opnd_qj = TAG_W'(TAG_NONE);
        end
        if (bus.Cdb_Valid && (bus.Rst_Qi_K != TAG_W'(TAG_NONE)) && (bus.Cdb_Tag == bus.Rst_Qi_K)) begin
            opnd_vk = bus.Cdb_Data;
            opnd_qk = TAG_W'(TAG_NONE);
        end
`endif
    end

`ifndef DISPATCH_CDB_BYPASS_EN
    logic cdb_unused;
    assign cdb_unused = ^{bus.Cdb_Valid, bus.Cdb_Tag, bus.Cdb_Data};
`endif

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        tag_d     = tag_q;
        vj_d      = vj_q;
        vk_d      = vk_q;
        qj_d      = qj_q;
        qk_d      = qk_q;
        illegal_d = 1'b0;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.Queue_Empty) begin
                    pop     = 1'b1;
                    ir_d    = bus.Queue_Instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE, ST_STALL: begin
                if (!op_is_add(ir_op) && !op_is_mul(ir_op)) begin
                    illegal_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    vj_d = opnd_vj;
                    vk_d = opnd_vk;
                    qj_d = opnd_qj;
                    qk_d = opnd_qk;
                    if (sel_found) begin
                        tag_d   = sel_tag;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_STALL;
                    end
                end
            end
            ST_ISSUE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            tag_q     <= '0;
            vj_q      <= '0;
            vk_q      <= '0;
            qj_q      <= '0;
            qk_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            tag_q     <= tag_d;
            vj_q      <= vj_d;
            vk_q      <= vk_d;
            qj_q      <= qj_d;
            qk_q      <= qk_d;
            illegal_q <= illegal_d;
        end
    end

    // Pop is decoded from IDLE, which is also the reset state, so it is
    // qualified with reset to stay low while reset is held.
    assign bus.Pop         = pop & rst_n;
    assign bus.Rf_Addr_J   = ir_q[RS_LSB +: 4];
    assign bus.Rf_Addr_K   = ir_q[RT_LSB +: 4];
    assign bus.Issue_Valid = (state_q == ST_ISSUE);
    assign bus.Issue_Tag   = tag_q;
    assign bus.Issue_Op    = ir_op;
    assign bus.Issue_Vj    = vj_q;
    assign bus.Issue_Vk    = vk_q;
    assign bus.Issue_Qj    = qj_q;
    assign bus.Issue_Qk    = qk_q;
    assign bus.Rst_Write   = (state_q == ST_ISSUE);
    assign bus.Rst_Addr    = ir_q[RD_LSB +: 4];
    assign bus.Rst_Tag     = tag_q;
    assign bus.Illegal     = illegal_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed bench for instr_dispatch: register file and status table are
// modelled as tb arrays; expected values are hand-computed per scenario.
module tb_instr_dispatch;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    logic [15:0] rf [16];
    logic [2:0]  qi [16];

    instr_dispatch_if #(.DATA_W(16), .TAG_W(3)) bus ();

    instr_dispatch #(.DATA_W(16), .TAG_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.Rf_Data_J = rf[bus.Rf_Addr_J];
    assign bus.Rf_Data_K = rf[bus.Rf_Addr_K];
    assign bus.Rst_Qi_J  = qi[bus.Rf_Addr_J];
    assign bus.Rst_Qi_K  = qi[bus.Rf_Addr_K];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_env();
        for (int i = 0; i < 16; i++) begin
            rf[i] = 16'h0;
            qi[i] = 3'd0;
        end
        bus.Queue_Empty = 1'b1;
        bus.Queue_Instr = 16'h0;
        bus.Add_Busy    = 3'b000;
        bus.Mul_Busy    = 2'b00;
        bus.Cdb_Valid   = 1'b0;
        bus.Cdb_Tag     = 3'd0;
        bus.Cdb_Data    = 16'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.Queue_Empty = 1'b0;
        bus.Queue_Instr = 16'h0012;
        #12;
        total++; if (bus.Pop !== 1'b0) $display("FAIL rst_pop got %b want 0", bus.Pop); else passed++;
        total++; if (bus.Issue_Valid !== 1'b0 || bus.Rst_Write !== 1'b0 || bus.Illegal !== 1'b0)
            $display("FAIL rst_strobes got %b%b%b want 000", bus.Issue_Valid, bus.Rst_Write, bus.Illegal); else passed++;
        total++; if (bus.Issue_Tag !== 3'd0 || bus.Issue_Vj !== 16'h0 || bus.Rf_Addr_J !== 4'h0)
            $display("FAIL rst_data got tag=%0d vj=%h addr=%h want 0", bus.Issue_Tag, bus.Issue_Vj, bus.Rf_Addr_J); else passed++;
        bus.Queue_Empty = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        rf[1] = 16'd5; rf[2] = 16'd7;
        bus.Queue_Instr = 16'h0012;
        bus.Queue_Empty = 1'b0;
        #1;
        total++; if (bus.Pop !== 1'b1) $display("FAIL add_pop got %b want 1", bus.Pop); else passed++;
        @(negedge clk);
        bus.Queue_Empty = 1'b1;
        #1;
        total++; if (bus.Pop !== 1'b0 || bus.Issue_Valid !== 1'b0)
            $display("FAIL add_decode got pop=%b iv=%b want 0 0", bus.Pop, bus.Issue_Valid); else passed++;
        total++; if (bus.Rf_Addr_J !== 4'd1 || bus.Rf_Addr_K !== 4'd2)
            $display("FAIL add_rfaddr got %0d,%0d want 1,2", bus.Rf_Addr_J, bus.Rf_Addr_K); else passed++;
        @(negedge clk);
        total++; if (bus.Issue_Valid !== 1'b1 || bus.Rst_Write !== 1'b1)
            $display("FAIL add_issue got iv=%b rw=%b want 1 1", bus.Issue_Valid, bus.Rst_Write); else passed++;
        total++; if (bus.Issue_Tag !== 3'd1 || bus.Rst_Tag !== 3'd1 || bus.Rst_Addr !== 4'd0 || bus.Issue_Op !== 4'd0)
            $display("FAIL add_tag got tag=%0d rtag=%0d raddr=%0d op=%0d want 1 1 0 0",
                     bus.Issue_Tag, bus.Rst_Tag, bus.Rst_Addr, bus.Issue_Op); else passed++;
        total++; if (bus.Issue_Vj !== 16'd5 || bus.Issue_Vk !== 16'd7 || bus.Issue_Qj !== 3'd0 || bus.Issue_Qk !== 3'd0)
            $display("FAIL add_opnd got vj=%0d vk=%0d qj=%0d qk=%0d want 5 7 0 0",
                     bus.Issue_Vj, bus.Issue_Vk, bus.Issue_Qj, bus.Issue_Qk); else passed++;
        @(negedge clk);
        total++; if (bus.Issue_Valid !== 1'b0 || bus.Rst_Write !== 1'b0)
            $display("FAIL add_oneshot got iv=%b rw=%b want 0 0", bus.Issue_Valid, bus.Rst_Write); else passed++;
    endtask

    task automatic test_mul_stall();
        bus.Mul_Busy    = 2'b11;
        bus.Queue_Instr = 16'h2012;
        bus.Queue_Empty = 1'b0;
        @(negedge clk);
        bus.Queue_Empty = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.Issue_Valid !== 1'b0 || bus.Pop !== 1'b0)
            $display("FAIL mul_stall got iv=%b pop=%b want 0 0", bus.Issue_Valid, bus.Pop); else passed++;
        bus.Mul_Busy = 2'b01;
        @(negedge clk);
        total++; if (bus.Issue_Valid !== 1'b1 || bus.Issue_Tag !== 3'd5 || bus.Issue_Op !== 4'd2)
            $display("FAIL mul_issue got iv=%b tag=%0d op=%0d want 1 5 2", bus.Issue_Valid, bus.Issue_Tag, bus.Issue_Op); else passed++;
        bus.Mul_Busy = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_sub_busy();
        bus.Add_Busy    = 3'b011;
        qi[2]           = 3'd2;
        bus.Queue_Instr = 16'h1312;
        bus.Queue_Empty = 1'b0;
        @(negedge clk);
        bus.Queue_Empty = 1'b1;
        @(negedge clk);
        total++; if (bus.Issue_Valid !== 1'b1 || bus.Issue_Tag !== 3'd3 || bus.Issue_Op !== 4'd1 || bus.Rst_Addr !== 4'd3)
            $display("FAIL sub_issue got iv=%b tag=%0d op=%0d raddr=%0d want 1 3 1 3",
                     bus.Issue_Valid, bus.Issue_Tag, bus.Issue_Op, bus.Rst_Addr); else passed++;
        total++; if (bus.Issue_Qk !== 3'd2 || bus.Issue_Vk !== 16'd0 || bus.Issue_Vj !== 16'd5)
            $display("FAIL sub_opnd got qk=%0d vk=%0d vj=%0d want 2 0 5", bus.Issue_Qk, bus.Issue_Vk, bus.Issue_Vj); else passed++;
        bus.Add_Busy = 3'b000;
        qi[2]        = 3'd0;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        int ill_cnt;
        int iv_cnt;
        ill_cnt = 0;
        iv_cnt  = 0;
        bus.Queue_Instr = 16'hF000;
        bus.Queue_Empty = 1'b0;
        @(negedge clk);
        bus.Queue_Empty = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.Illegal === 1'b1) ill_cnt++;
            if (bus.Issue_Valid === 1'b1 || bus.Rst_Write === 1'b1) iv_cnt++;
        end
        total++; if (ill_cnt !== 1) $display("FAIL illegal_pulse got %0d cycles want 1", ill_cnt); else passed++;
        total++; if (iv_cnt !== 0) $display("FAIL illegal_noissue got %0d cycles want 0", iv_cnt); else passed++;
        // Same-register operands: R1 <- R3 + R3
        rf[3] = 16'd11;
        bus.Queue_Instr = 16'h0133;
        bus.Queue_Empty = 1'b0;
        #1;
        total++; if (bus.Pop !== 1'b1) $display("FAIL illegal_idle got pop=%b want 1", bus.Pop); else passed++;
        @(negedge clk);
        bus.Queue_Empty = 1'b1;
        @(negedge clk);
        total++; if (bus.Issue_Valid !== 1'b1 || bus.Issue_Vj !== 16'd11 || bus.Issue_Vk !== 16'd11 || bus.Rst_Addr !== 4'd1)
            $display("FAIL same_reg got iv=%b vj=%0d vk=%0d raddr=%0d want 1 11 11 1",
                     bus.Issue_Valid, bus.Issue_Vj, bus.Issue_Vk, bus.Rst_Addr); else passed++;
        @(negedge clk);
    endtask

    task automatic test_bypass();
        logic [2:0]  exp_qj;
        logic [15:0] exp_vj;
`ifdef DISPATCH_CDB_BYPASS_EN
        exp_qj = 3'd0; exp_vj = 16'd9;
`else
        exp_qj = 3'd4; exp_vj = 16'd0;
`endif
        qi[1]           = 3'd4;
        bus.Cdb_Valid   = 1'b1;
        bus.Cdb_Tag     = 3'd4;
        bus.Cdb_Data    = 16'd9;
        bus.Queue_Instr = 16'h0012;
        bus.Queue_Empty = 1'b0;
        @(negedge clk);
        bus.Queue_Empty = 1'b1;
        @(negedge clk);
        total++; if (bus.Issue_Valid !== 1'b1 || bus.Issue_Qj !== exp_qj || bus.Issue_Vj !== exp_vj)
            $display("FAIL bypass got iv=%b qj=%0d vj=%0d want 1 %0d %0d",
                     bus.Issue_Valid, bus.Issue_Qj, bus.Issue_Vj, exp_qj, exp_vj); else passed++;
        total++; if (bus.Issue_Qk !== 3'd0 || bus.Issue_Vk !== 16'd7)
            $display("FAIL bypass_k got qk=%0d vk=%0d want 0 7", bus.Issue_Qk, bus.Issue_Vk); else passed++;
        qi[1]         = 3'd0;
        bus.Cdb_Valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0] pops;
        rf[4] = 16'd3;
        bus.Queue_Instr = 16'h0012;
        bus.Queue_Empty = 1'b0;
        #1;
        pops[0] = bus.Pop;
        @(negedge clk);
        bus.Queue_Instr = 16'h2034;
        #1; pops[1] = bus.Pop;
        @(negedge clk);
        #1; pops[2] = bus.Pop;
        total++; if (bus.Issue_Valid !== 1'b1 || bus.Issue_Tag !== 3'd1)
            $display("FAIL b2b_first got iv=%b tag=%0d want 1 1", bus.Issue_Valid, bus.Issue_Tag); else passed++;
        @(negedge clk);
        #1; pops[3] = bus.Pop;
        total++; if (pops !== 4'b1001) $display("FAIL b2b_pop got %b want 1001", pops); else passed++;
        @(negedge clk);
        bus.Queue_Empty = 1'b1;
        @(negedge clk);
        total++; if (bus.Issue_Valid !== 1'b1 || bus.Issue_Tag !== 3'd4 || bus.Issue_Vj !== 16'd11 || bus.Issue_Vk !== 16'd3)
            $display("FAIL b2b_second got iv=%b tag=%0d vj=%0d vk=%0d want 1 4 11 3",
                     bus.Issue_Valid, bus.Issue_Tag, bus.Issue_Vj, bus.Issue_Vk); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_stall();
        int iv_cnt;
        iv_cnt = 0;
        bus.Mul_Busy    = 2'b11;
        bus.Queue_Instr = 16'h2012;
        bus.Queue_Empty = 1'b0;
        @(negedge clk);
        bus.Queue_Empty = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (bus.Issue_Valid !== 1'b0 || bus.Rst_Write !== 1'b0 || bus.Pop !== 1'b0 || bus.Illegal !== 1'b0)
            $display("FAIL rststall_strobes got iv=%b rw=%b pop=%b ill=%b want 0000",
                     bus.Issue_Valid, bus.Rst_Write, bus.Pop, bus.Illegal); else passed++;
        total++; if (bus.Issue_Vj !== 16'h0 || bus.Issue_Op !== 4'h0 || bus.Rf_Addr_J !== 4'h0 || bus.Rst_Addr !== 4'h0)
            $display("FAIL rststall_data got vj=%h op=%h addr=%h raddr=%h want 0",
                     bus.Issue_Vj, bus.Issue_Op, bus.Rf_Addr_J, bus.Rst_Addr); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        bus.Mul_Busy = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.Issue_Valid === 1'b1) iv_cnt++;
        end
        total++; if (iv_cnt !== 0) $display("FAIL rststall_noissue got %0d issues want 0", iv_cnt); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        clear_env();
        test_reset();
        test_add();
        test_mul_stall();
        test_sub_busy();
        test_illegal();
        test_bypass();
        test_back_to_back();
        test_reset_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
